seq_alu: RTL

Parametrised, registered successor to the datapath ALU. It keeps the existing 4-bit control encoding and adds SRA, unsigned iterative multiply and divide with HI/LO registers, and MFHI/MFLO reads. A start/busy/valid handshake lets the pipeline stall the EX stage while a multi-cycle operation runs. It sits in EX, fed by the ALU control decoder.

---
 rtl/seq_alu.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered EX-stage ALU with iterative unsigned multiply/divide.
//
// Keeps the legacy 4-bit ALU control encoding. Adds SRA, MULTU, DIVU and
// MFHI/MFLO. Multi-cycle operations use a start/busy/valid handshake so the
// pipeline can stall.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   start_i      request, accepted when busy_o=0
//   ctrl_i       operation code, sampled at acceptance
//   src1_i       operand A, sampled at acceptance
//   src2_i       operand B, sampled at acceptance
//   shamt_i      immediate shift amount
//   busy_o       multi-cycle operation in progress
//   valid_o      one-cycle pulse qualifying result_o, zero_o, div_zero_o
//   result_o     registered result, held until the next accepted operation
//   zero_o       result_o == 0
//   hi_o, lo_o   HI/LO registers
//   div_zero_o   current DIVU had a zero divisor (qualified by valid_o)
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [3:0]         ctrl_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               div_zero_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFLO  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SLLV  = 4'b1010;
  localparam logic [3:0] OP_SRLV  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_PASS  = 4'b1111;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  logic [1:0]           state_q,    state_d;
  logic [SHAMT_W-1:0]   cnt_q,      cnt_d;
  logic [2*WIDTH-1:0]   acc_q,      acc_d;
  logic [WIDTH-1:0]     opb_q,      opb_d;
  logic [WIDTH-1:0]     result_q,   result_d;
  logic [WIDTH-1:0]     hi_q,       hi_d;
  logic [WIDTH-1:0]     lo_q,       lo_d;
  logic                 valid_q,    valid_d;
  logic                 div_zero_q, div_zero_d;

  logic [WIDTH-1:0]     alu_res;
  logic [SHAMT_W-1:0]   sh_var;
  logic                 slt_bit;

  logic [WIDTH-1:0]     mul_add;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_rem_sh;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   iter_next;

  // Single-cycle operations
  always_comb begin
    sh_var  = src1_i[SHAMT_W-1:0];
    slt_bit = $signed(src1_i) < $signed(src2_i);
    alu_res = '0;
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_NOR:  alu_res = ~(src1_i | src2_i);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLL:  alu_res = src2_i << shamt_i;
      OP_SRL:  alu_res = src2_i >> shamt_i;
      OP_SRA:  alu_res = $unsigned($signed(src2_i) >>> shamt_i);
      OP_SLLV: alu_res = src2_i << sh_var;
      OP_SRLV: alu_res = src2_i >> sh_var;
      OP_PASS: alu_res = src1_i;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // One iteration of each iterative unit. acc_q holds {partial, operand}:
  // multiply: {upper product, multiplier}, shifting right;
  // divide:   {remainder, dividend/quotient}, shifting left.
  always_comb begin
    mul_add    = acc_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

    div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff   = div_rem_sh - {1'b0, opb_q};
    div_ge     = ~div_diff[WIDTH];
    div_next   = {(div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};

    iter_next  = (state_q == ST_MUL) ? mul_next : div_next;
  end

  // Control and next-state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    result_d   = result_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    valid_d    = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (ctrl_i)
            OP_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = '0;
              opb_d   = src1_i;
              acc_d   = {{WIDTH{1'b0}}, src2_i};
            end
            OP_DIVU: begin
              if (src2_i == '0) begin
                lo_d       = '1;
                hi_d       = src1_i;
                result_d   = '1;
                valid_d    = 1'b1;
                div_zero_d = 1'b1;
              end else begin
                state_d = ST_DIV;
                cnt_d   = '0;
                opb_d   = src2_i;
                acc_d   = {{WIDTH{1'b0}}, src1_i};
              end
            end
            default: begin
              result_d = alu_res;
              valid_d  = 1'b1;
            end
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_IDLE;
          hi_d     = iter_next[2*WIDTH-1:WIDTH];
          lo_d     = iter_next[WIDTH-1:0];
          result_d = iter_next[WIDTH-1:0];
          valid_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      valid_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      valid_q    <= valid_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign zero_o     = (result_q == '0);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = div_zero_q;

endmodule
